wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//  Shares the two physical-regfile write ports among NUM_REQ writeback units (alu1, alu2, falu1, falu2, lsu, md).
//  Grants at most 2 requesters per cycle, using rotating round-robin priority with valid/ready handshakes.
//  Registers the winners onto wr_first/wr_second, which feed the regfile write ports with 1-cycle latency.
// PARAMETERS
//  NUM_REQ         6    number of writeback requesters (index 0 = alu1 ... 5 = md)
//  REG_SIZE_WIDTH  6    physical register address width
//  XLEN            64   data width
//  PTR_W           3    width of rr_ptr; must satisfy 2**PTR_W >= NUM_REQ
// PORTS
//  clk               in   1                     clock
//  rst_n             in   1                     reset; synchronous, active-low
//  req_valid_i       in   NUM_REQ               per-requester writeback valid
//  req_addr_i        in   NUM_REQ*REG_SIZE_WIDTH  packed prd; requester k at [k*REG_SIZE_WIDTH +: REG_SIZE_WIDTH]
//  req_data_i        in   NUM_REQ*XLEN          packed data; requester k at [k*XLEN +: XLEN]
//  req_ready_o       out  NUM_REQ               grant; transfer occurs when valid&ready in the same cycle
//  wr_first_valid_o  out  1                     regfile port 0 write enable
//  wr_first_addr_o   out  REG_SIZE_WIDTH        regfile port 0 address
//  wr_first_data_o   out  XLEN                  regfile port 0 data
//  wr_second_valid_o out  1                     regfile port 1 write enable
//  wr_second_addr_o  out  REG_SIZE_WIDTH        regfile port 1 address
//  wr_second_data_o  out  XLEN                  regfile port 1 data
//  collision_o       out  1                     registered pulse: both grants targeted the same prd
// BEHAVIOUR
//  Clock and reset: one clock; reset is synchronous and active-low.
//  Grant selection (combinational)
//   - g0 = first valid index scanning rr_ptr, rr_ptr+1, ... (mod NUM_REQ).
//   - g1 = next valid index after g0 in the same scan order.
//   - req_ready_o is one-hot-or-two-hot at {g0,g1}; it is 0 for non-valid requesters.
//   - req_ready_o depends combinationally on req_valid_i. Requesters hold valid, addr and data stable until ready.
//   - While rst_n=0: req_ready_o = 0.
//  Output stage (registered, latency 1)
//   - Cycle after the grant: wr_first <= g0 addr/data; wr_second <= g1 addr/data.
//   - Only one grant: the first port carries it; wr_second_valid_o = 0.
//   - No grants: both valids 0; addr/data hold their previous values.
//   - prd == 0: the request is still granted and consumed, but that port's valid is forced 0 (P0 is never written).
//   - g0.addr == g1.addr (nonzero): both are consumed; wr_first_valid_o = 0; wr_second carries g1; collision_o = 1 for one cycle.
//  Round-robin pointer
//   - Reset value is 0.
//   - On any grant: rr_ptr <= (last granted index + 1) mod NUM_REQ. Wrap-around is explicit, e.g. g1 = 5 -> rr_ptr = 0.
//   - No grants: rr_ptr holds.
//   - Every continuously-valid requester is granted within ceil(NUM_REQ/2) cycles.
//  Reset values: wr_*_valid_o = 0, wr_*_addr_o = 0, wr_*_data_o = 0, collision_o = 0, rr_ptr = 0.
//  Reset mid-operation: the registered write in flight is dropped (valids cleared); no requester is acked during reset.
// CONFIGURATION
//  WB_ARB_PERF_EN defined:
//   - Adds output perf_conflict_cnt_o [31:0]. It counts cycles with >2 valid requesters (at least one denied).
//   - The counter saturates at 2**32-1 and resets to 0.
//  WB_ARB_PERF_EN undefined: the port and the counter are absent; behaviour is otherwise identical.
// TESTING
//  1. rst_n=0 with all valid=1 for 3 cycles -> req_ready_o=0, wr_*_valid_o=0, collision_o=0; after release the first grants are {0,1}.
//  2. Only req 2 valid, addr 5, data 0xAA -> req_ready_o=6'b000100 same cycle; next cycle wr_first=(1,5,0xAA), wr_second_valid=0.
//  3. All 6 valid and held (addr k+1) -> grant pairs {0,1},{2,3},{4,5},{0,1}; each pair appears on the ports one cycle later; rr_ptr wraps 5->0.
//  4. Only req 3 valid, addr 0 -> req_ready_o[3]=1; next cycle both wr valids=0.
//  5. req 1 and req 4 valid, both addr 7, data 0x11/0x44 -> both ready; next cycle wr_first_valid=0, wr_second=(1,7,0x44), collision_o=1.
//  6. WB_ARB_PERF_EN: all 6 valid for 10 cycles, then 2 valid for 5 cycles -> perf_conflict_cnt_o=10.

Source files
------------

// File: rtl/wb_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter_if
// Description : Writeback bus between the execution units, the writeback
//               arbiter and the two physical-regfile write ports.
//               master = requester/regfile side, slave = arbiter side.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_port_arbiter_if #(
  parameter int NUM_REQ        = 6,
  parameter int REG_SIZE_WIDTH = 6,
  parameter int XLEN           = 64
);

  // Requester side
  logic [NUM_REQ-1:0]                req_valid_i;
  logic [NUM_REQ*REG_SIZE_WIDTH-1:0] req_addr_i;
  logic [NUM_REQ*XLEN-1:0]           req_data_i;
  logic [NUM_REQ-1:0]                req_ready_o;

  // Regfile write port 0
  logic                              wr_first_valid_o;
  logic [REG_SIZE_WIDTH-1:0]         wr_first_addr_o;
  logic [XLEN-1:0]                   wr_first_data_o;

  // Regfile write port 1
  logic                              wr_second_valid_o;
  logic [REG_SIZE_WIDTH-1:0]         wr_second_addr_o;
  logic [XLEN-1:0]                   wr_second_data_o;

  // Same-prd collision pulse
  logic                              collision_o;

  modport master (
    output req_valid_i,
    output req_addr_i,
    output req_data_i,
    input  req_ready_o,
    input  wr_first_valid_o,
    input  wr_first_addr_o,
    input  wr_first_data_o,
    input  wr_second_valid_o,
    input  wr_second_addr_o,
    input  wr_second_data_o,
    input  collision_o
  );

  modport slave (
    input  req_valid_i,
    input  req_addr_i,
    input  req_data_i,
    output req_ready_o,
    output wr_first_valid_o,
    output wr_first_addr_o,
    output wr_first_data_o,
    output wr_second_valid_o,
    output wr_second_addr_o,
    output wr_second_data_o,
    output collision_o
  );

endinterface
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter
// Description : Shares the two regfile write ports among NUM_REQ writeback
//               units. Up to two requesters are granted per cycle in rotating
//               round-robin order; winners are registered onto the write
//               ports with one cycle of latency.
//               Optional macro WB_ARB_PERF_EN adds perf_conflict_cnt_o, a
//               saturating count of cycles with more than two requesters.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter #(
  parameter int NUM_REQ        = 6,
  parameter int REG_SIZE_WIDTH = 6,
  parameter int XLEN           = 64,
  parameter int PTR_W          = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  wb_port_arbiter_if.slave   bus
`ifdef WB_ARB_PERF_EN
  ,
  output logic [31:0]        perf_conflict_cnt_o
`endif
);

  localparam int c_CNT_W = $clog2(NUM_REQ + 1);

  // Unpacked per-requester address/data
  logic [REG_SIZE_WIDTH-1:0] w_addr [NUM_REQ];
  logic [XLEN-1:0]           w_data [NUM_REQ];

  // Scan order starting at the round-robin pointer
  logic [PTR_W-1:0]          w_scan_idx [NUM_REQ];

  // Grant results
  logic                      w_g0_found;
  logic                      w_g1_found;
  logic [PTR_W-1:0]          w_g0_idx;
  logic [PTR_W-1:0]          w_g1_idx;
  logic [PTR_W-1:0]          w_last_idx;
  logic                      w_same_addr;
  logic [NUM_REQ-1:0]        w_ready;

  // Registered state
  logic [PTR_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic                      wr_first_valid_q, wr_first_valid_d;
  logic [REG_SIZE_WIDTH-1:0] wr_first_addr_q, wr_first_addr_d;
  logic [XLEN-1:0]           wr_first_data_q, wr_first_data_d;
  logic                      wr_second_valid_q, wr_second_valid_d;
  logic [REG_SIZE_WIDTH-1:0] wr_second_addr_q, wr_second_addr_d;
  logic [XLEN-1:0]           wr_second_data_q, wr_second_data_d;
  logic                      collision_q, collision_d;

  generate
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
      assign w_addr[k] = bus.req_addr_i[k*REG_SIZE_WIDTH +: REG_SIZE_WIDTH];
      assign w_data[k] = bus.req_data_i[k*XLEN +: XLEN];
    end

    // Position i of the scan is (rr_ptr + i) mod NUM_REQ; the pointer is
    // always below NUM_REQ so one conditional subtract suffices.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_scan
      logic [PTR_W:0] w_sum;
      assign w_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
      assign w_scan_idx[i] = (w_sum >= (PTR_W+1)'(NUM_REQ))
                           ? PTR_W'(w_sum - (PTR_W+1)'(NUM_REQ))
                           : w_sum[PTR_W-1:0];
    end
  endgenerate

  // Pick the first two valid requesters in rotating scan order
  always_comb begin
    w_g0_found = 1'b0;
    w_g1_found = 1'b0;
    w_g0_idx   = '0;
    w_g1_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.req_valid_i[w_scan_idx[i]]) begin
        if (!w_g0_found) begin
          w_g0_found = 1'b1;
          w_g0_idx   = w_scan_idx[i];
        end else if (!w_g1_found) begin
          w_g1_found = 1'b1;
          w_g1_idx   = w_scan_idx[i];
        end
      end
    end
  end

  // Ready is the grant vector, suppressed entirely while in reset
  always_comb begin
    w_ready = '0;
    if (rst_n) begin
      if (w_g0_found) w_ready[w_g0_idx] = 1'b1;
      if (w_g1_found) w_ready[w_g1_idx] = 1'b1;
    end
  end

  assign bus.req_ready_o = w_ready;

  // Pointer moves just past the last granted index, wrapping at NUM_REQ
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    w_last_idx = w_g1_found ? w_g1_idx : w_g0_idx;
    if (w_g0_found) begin
      rr_ptr_d = (w_last_idx == PTR_W'(NUM_REQ - 1)) ? '0
                                                     : w_last_idx + PTR_W'(1);
    end
  end

  // Next write-port contents; prd 0 is consumed but never written, and a
  // same-prd pair keeps only the younger-in-scan grant on port 1
  always_comb begin
    wr_first_valid_d  = 1'b0;
    wr_first_addr_d   = wr_first_addr_q;
    wr_first_data_d   = wr_first_data_q;
    wr_second_valid_d = 1'b0;
    wr_second_addr_d  = wr_second_addr_q;
    wr_second_data_d  = wr_second_data_q;
    collision_d       = 1'b0;
    w_same_addr       = w_g1_found && (w_addr[w_g0_idx] == w_addr[w_g1_idx]);

    if (w_g0_found) begin
      wr_first_addr_d  = w_addr[w_g0_idx];
      wr_first_data_d  = w_data[w_g0_idx];
      wr_first_valid_d = (w_addr[w_g0_idx] != '0) && !w_same_addr;
    end
    if (w_g1_found) begin
      wr_second_addr_d  = w_addr[w_g1_idx];
      wr_second_data_d  = w_data[w_g1_idx];
      wr_second_valid_d = (w_addr[w_g1_idx] != '0);
    end
    collision_d = w_same_addr && (w_addr[w_g0_idx] != '0);
  end

  // State and output registers; reset drops any write in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q          <= '0;
      wr_first_valid_q  <= 1'b0;
      wr_first_addr_q   <= '0;
      wr_first_data_q   <= '0;
      wr_second_valid_q <= 1'b0;
      wr_second_addr_q  <= '0;
      wr_second_data_q  <= '0;
      collision_q       <= 1'b0;
    end else begin
      rr_ptr_q          <= rr_ptr_d;
      wr_first_valid_q  <= wr_first_valid_d;
      wr_first_addr_q   <= wr_first_addr_d;
      wr_first_data_q   <= wr_first_data_d;
      wr_second_valid_q <= wr_second_valid_d;
      wr_second_addr_q  <= wr_second_addr_d;
      wr_second_data_q  <= wr_second_data_d;
      collision_q       <= collision_d;
    end
  end

  assign bus.wr_first_valid_o  = wr_first_valid_q;
  assign bus.wr_first_addr_o   = wr_first_addr_q;
  assign bus.wr_first_data_o   = wr_first_data_q;
  assign bus.wr_second_valid_o = wr_second_valid_q;
  assign bus.wr_second_addr_o  = wr_second_addr_q;
  assign bus.wr_second_data_o  = wr_second_data_q;
  assign bus.collision_o       = collision_q;

`ifdef WB_ARB_PERF_EN
  logic [c_CNT_W-1:0] w_valid_cnt;
  logic [31:0]        perf_cnt_q, perf_cnt_d;

  // Count cycles where more than two units compete (someone is denied)
  always_comb begin
    w_valid_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_valid_cnt = w_valid_cnt + c_CNT_W'(bus.req_valid_i[i]);
    end
    perf_cnt_d = perf_cnt_q;
    if ((w_valid_cnt > c_CNT_W'(2)) && (perf_cnt_q != 32'hFFFF_FFFF)) begin
      perf_cnt_d = perf_cnt_q + 32'd1;
    end
  end

  // Saturating conflict counter register
  always_ff @(posedge clk) begin
    if (!rst_n) perf_cnt_q <= '0;
    else        perf_cnt_q <= perf_cnt_d;
  end

  assign perf_conflict_cnt_o = perf_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_port_arbiter
// Description : Scoreboard bench for wb_port_arbiter. Stimulus pushes the
//               expected ready vector and next-cycle write-port contents;
//               a negedge monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

  localparam int NUM_REQ = 6;
  localparam int RW      = 6;
  localparam int XLEN    = 64;

  typedef struct {
    int          cyc;
    logic [5:0]  rdy;
  } rdy_exp_t;

  typedef struct {
    int          cyc;
    logic        fv;
    logic [5:0]  fa;
    logic [63:0] fd;
    logic        cf;
    logic        sv;
    logic [5:0]  sa;
    logic [63:0] sd;
    logic        cs;
    logic        col;
  } wr_exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;

  rdy_exp_t rq[$];
  wr_exp_t  wq[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  wb_port_arbiter_if #(.NUM_REQ(NUM_REQ), .REG_SIZE_WIDTH(RW), .XLEN(XLEN)) bus ();

`ifdef WB_ARB_PERF_EN
  logic [31:0] perf_cnt;
`endif

  wb_port_arbiter #(
    .NUM_REQ(NUM_REQ), .REG_SIZE_WIDTH(RW), .XLEN(XLEN), .PTR_W(3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef WB_ARB_PERF_EN
    ,
    .perf_conflict_cnt_o (perf_cnt)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compare DUT outputs against the queued expectations
  always @(negedge clk) begin
    while (rq.size() > 0 && rq[0].cyc < cyc) begin
      errors++;
      $display("FAIL ready_missed: expectation for cyc %0d not checked, now %0d", rq[0].cyc, cyc);
      void'(rq.pop_front());
    end
    while (wq.size() > 0 && wq[0].cyc < cyc) begin
      errors++;
      $display("FAIL wr_missed: expectation for cyc %0d not checked, now %0d", wq[0].cyc, cyc);
      void'(wq.pop_front());
    end
    if (rq.size() > 0 && rq[0].cyc == cyc) begin
      rdy_exp_t r;
      r = rq.pop_front();
      chk("req_ready", 64'(bus.req_ready_o), 64'(r.rdy));
    end
    if (wq.size() > 0 && wq[0].cyc == cyc) begin
      wr_exp_t e;
      e = wq.pop_front();
      chk("first_valid", 64'(bus.wr_first_valid_o), 64'(e.fv));
      chk("second_valid", 64'(bus.wr_second_valid_o), 64'(e.sv));
      chk("collision", 64'(bus.collision_o), 64'(e.col));
      if (e.cf) begin
        chk("first_addr", 64'(bus.wr_first_addr_o), 64'(e.fa));
        chk("first_data", bus.wr_first_data_o, e.fd);
      end
      if (e.cs) begin
        chk("second_addr", 64'(bus.wr_second_addr_o), 64'(e.sa));
        chk("second_data", bus.wr_second_data_o, e.sd);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_rdy(input logic [5:0] r);
    rdy_exp_t e;
    e.cyc = cyc;
    e.rdy = r;
    rq.push_back(e);
  endtask

  task automatic exp_wr(input int at,
                        input logic fv, input logic [5:0] fa, input logic [63:0] fd, input logic cf,
                        input logic sv, input logic [5:0] sa, input logic [63:0] sd, input logic cs,
                        input logic col);
    wr_exp_t e;
    e.cyc = at; e.fv = fv; e.fa = fa; e.fd = fd; e.cf = cf;
    e.sv = sv; e.sa = sa; e.sd = sd; e.cs = cs; e.col = col;
    wq.push_back(e);
  endtask

  task automatic set_req(input int k, input logic [5:0] a, input logic [63:0] d);
    bus.req_addr_i[k*RW +: RW]     = a;
    bus.req_data_i[k*XLEN +: XLEN] = d;
  endtask

  // Requester k: addr k+1, data A5A5_0000_0000_000k
  task automatic set_all();
    for (int k = 0; k < NUM_REQ; k++) set_req(k, 6'(k + 1), 64'hA5A5_0000_0000_0000 | 64'(k));
  endtask

  localparam logic [63:0] D0 = 64'hA5A5_0000_0000_0000;
  localparam logic [63:0] D1 = 64'hA5A5_0000_0000_0001;
  localparam logic [63:0] D2 = 64'hA5A5_0000_0000_0002;
  localparam logic [63:0] D3 = 64'hA5A5_0000_0000_0003;
  localparam logic [63:0] D4 = 64'hA5A5_0000_0000_0004;
  localparam logic [63:0] D5 = 64'hA5A5_0000_0000_0005;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] pair;
    bus.req_valid_i = 6'h3F;
    bus.req_addr_i  = '0;
    bus.req_data_i  = '0;
    set_all();

    // Reset with everyone valid: no acks, outputs cleared
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_rdy(6'b000000);
      exp_wr(cyc, 1'b0, 6'd0, 64'd0, 1'b1, 1'b0, 6'd0, 64'd0, 1'b1, 1'b0);
    end

    // Release: all six held valid, pairs rotate and wrap
    tick(); rst_n = 1'b1;
    exp_rdy(6'b000011); exp_wr(cyc + 1, 1'b1, 6'd1, D0, 1'b1, 1'b1, 6'd2, D1, 1'b1, 1'b0);
    tick();
    exp_rdy(6'b001100); exp_wr(cyc + 1, 1'b1, 6'd3, D2, 1'b1, 1'b1, 6'd4, D3, 1'b1, 1'b0);
    tick();
    exp_rdy(6'b110000); exp_wr(cyc + 1, 1'b1, 6'd5, D4, 1'b1, 1'b1, 6'd6, D5, 1'b1, 1'b0);
    tick();
    exp_rdy(6'b000011); exp_wr(cyc + 1, 1'b1, 6'd1, D0, 1'b1, 1'b1, 6'd2, D1, 1'b1, 1'b0);

    // Idle: valids drop, addr/data hold
    tick(); bus.req_valid_i = 6'b000000;
    exp_rdy(6'b000000); exp_wr(cyc + 1, 1'b0, 6'd1, D0, 1'b1, 1'b0, 6'd2, D1, 1'b1, 1'b0);

    // Single requester 2: only port 0 written, port 1 holds
    tick(); bus.req_valid_i = 6'b000100; set_req(2, 6'd5, 64'hAA);
    exp_rdy(6'b000100); exp_wr(cyc + 1, 1'b1, 6'd5, 64'hAA, 1'b1, 1'b0, 6'd2, D1, 1'b1, 1'b0);
    tick(); bus.req_valid_i = 6'b000000;
    exp_rdy(6'b000000); exp_wr(cyc + 1, 1'b0, 6'd0, 64'd0, 1'b0, 1'b0, 6'd0, 64'd0, 1'b0, 1'b0);

    // prd 0 is consumed but never written
    tick(); bus.req_valid_i = 6'b001000; set_req(3, 6'd0, 64'h33);
    exp_rdy(6'b001000); exp_wr(cyc + 1, 1'b0, 6'd0, 64'h33, 1'b1, 1'b0, 6'd0, 64'd0, 1'b0, 1'b0);
    tick(); bus.req_valid_i = 6'b000000;
    exp_rdy(6'b000000); exp_wr(cyc + 1, 1'b0, 6'd0, 64'd0, 1'b0, 1'b0, 6'd0, 64'd0, 1'b0, 1'b0);

    // Single grant to index 5: pointer wraps to 0
    tick(); bus.req_valid_i = 6'b100000; set_req(5, 6'd9, 64'h55);
    exp_rdy(6'b100000); exp_wr(cyc + 1, 1'b1, 6'd9, 64'h55, 1'b1, 1'b0, 6'd0, 64'd0, 1'b0, 1'b0);
    tick(); bus.req_valid_i = 6'b000000;
    exp_rdy(6'b000000); exp_wr(cyc + 1, 1'b0, 6'd0, 64'd0, 1'b0, 1'b0, 6'd0, 64'd0, 1'b0, 1'b0);

    // Same-prd pair from pointer 0: port 0 suppressed, collision pulse
    tick(); bus.req_valid_i = 6'b010010; set_req(1, 6'd7, 64'h11); set_req(4, 6'd7, 64'h44);
    exp_rdy(6'b010010); exp_wr(cyc + 1, 1'b0, 6'd7, 64'h11, 1'b1, 1'b1, 6'd7, 64'h44, 1'b1, 1'b1);

    // Pointer 5: scan 5 then 0, collision pulse ends
    tick(); bus.req_valid_i = 6'b100001; set_req(0, 6'h0A, 64'hA0); set_req(5, 6'h0B, 64'hB0);
    exp_rdy(6'b100001); exp_wr(cyc + 1, 1'b1, 6'h0B, 64'hB0, 1'b1, 1'b1, 6'h0A, 64'hA0, 1'b1, 1'b0);

    // Pointer 1 with all valid
    tick(); bus.req_valid_i = 6'h3F; set_all();
    exp_rdy(6'b000110); exp_wr(cyc + 1, 1'b1, 6'd2, D1, 1'b1, 1'b1, 6'd3, D2, 1'b1, 1'b0);

    // Reset mid-operation: no acks, outputs cleared, pointer back to 0
    tick(); rst_n = 1'b0;
    exp_rdy(6'b000000); exp_wr(cyc + 1, 1'b0, 6'd0, 64'd0, 1'b1, 1'b0, 6'd0, 64'd0, 1'b1, 1'b0);
    tick();
    exp_rdy(6'b000000); exp_wr(cyc + 1, 1'b0, 6'd0, 64'd0, 1'b1, 1'b0, 6'd0, 64'd0, 1'b1, 1'b0);

    // Ten cycles of all valid, then five with two valid
    for (int j = 0; j < 10; j++) begin
      tick();
      if (j == 0) begin
        rst_n = 1'b1;
        exp_wr(cyc + 1, 1'b1, 6'd1, D0, 1'b1, 1'b1, 6'd2, D1, 1'b1, 1'b0);
      end
      pair = 6'b000011;
      exp_rdy(pair << (2 * (j % 3)));
    end
    for (int j = 0; j < 5; j++) begin
      tick();
      if (j == 0) bus.req_valid_i = 6'b000011;
      exp_rdy(6'b000011);
    end
    tick();
`ifdef WB_ARB_PERF_EN
    chk("perf_conflict_cnt", 64'(perf_cnt), 64'd10);
`endif
    bus.req_valid_i = 6'b000000;

    tick(); tick(); tick();
    chk("ready_queue_drained", 64'(rq.size()), 64'd0);
    chk("wr_queue_drained", 64'(wq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
